phase_unwrapper: RTL and testbench



---
 rtl/nice_pkg.sv | 16 +
 rtl/phase_averager.sv | 68 ++++++
 rtl/phase_unwrapper.sv | 109 ++++++++++
 tb/tb_phase_unwrapper.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/nice_pkg.sv
// Shared types and defaults for the phase unwrapper and its block averager.
package nice_pkg;

    localparam int PHASE_WIDTH_DEF = 24;
    localparam int TURN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ZERO  = 2'd1,
        TRACK = 2'd2
    } unwrap_state_t;

    typedef logic signed [PHASE_WIDTH_DEF-1:0]                wrapped_phase_t;
    typedef logic signed [PHASE_WIDTH_DEF+TURN_WIDTH_DEF-1:0] unwrapped_phase_t;

endpackage

// File: rtl/phase_averager.sv
// Block averager: sums 2^LOG2_AVG signed samples and emits the floored mean.
module phase_averager #(
    parameter int WIDTH    = 32,
    parameter int LOG2_AVG = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] avg,
    output logic             avg_valid
);

    localparam int SW = WIDTH + LOG2_AVG;

    logic [SW-1:0]       sum_reg, sum_next, sum_total, in_ext;
    logic [LOG2_AVG-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0]    avg_reg, avg_next;
    logic                avg_valid_reg, avg_valid_next;

    assign in_ext[WIDTH-1:0] = in;
    for (genvar gi = WIDTH; gi < SW; gi++) begin : g_in_sext
        assign in_ext[gi] = in[WIDTH-1];
    end

    assign sum_total = sum_reg + in_ext;

    always_comb begin
        sum_next       = sum_reg;
        cnt_next       = cnt_reg;
        avg_next       = avg_reg;
        avg_valid_next = 1'b0;
        if (clear) begin
            sum_next = '0;
            cnt_next = '0;
        end else if (in_valid) begin
            if (&cnt_reg) begin
                // Dropping the low bits of a two's-complement sum is a floor divide.
                avg_next       = sum_total[SW-1:LOG2_AVG];
                avg_valid_next = 1'b1;
                sum_next       = '0;
                cnt_next       = '0;
            end else begin
                sum_next = sum_total;
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sum_reg       <= '0;
            cnt_reg       <= '0;
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
        end else begin
            sum_reg       <= sum_next;
            cnt_reg       <= cnt_next;
            avg_reg       <= avg_next;
            avg_valid_reg <= avg_valid_next;
        end
    end

    assign avg       = avg_reg;
    assign avg_valid = avg_valid_reg;

endmodule

// File: rtl/phase_unwrapper.sv
// Turns the wrapped CORDIC phase into a continuous signed phase with whole-turn
// tracking, re-zeroing and a block-averaged readout.
module phase_unwrapper
    import nice_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int TURN_WIDTH  = TURN_WIDTH_DEF,
    parameter int LOG2_AVG    = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [PHASE_WIDTH-1:0]            phi_i,
    input  logic                              phi_valid_i,
    input  logic                              zero_i,
    output logic [PHASE_WIDTH+TURN_WIDTH-1:0] unwrapped_o,
    output logic                              unwrapped_valid_o,
    output logic [PHASE_WIDTH+TURN_WIDTH-1:0] avg_o,
    output logic                              avg_valid_o,
    output logic                              overflow_o
);

    localparam int OW = PHASE_WIDTH + TURN_WIDTH;

    unwrap_state_t          state_reg, state_next;
    logic [PHASE_WIDTH-1:0] prev_reg, prev_next, delta;
    logic [OW-1:0]          acc_reg, acc_next, delta_ext, phi_ext, acc_sum;
    logic                   valid_reg, valid_next, ovf_reg, ovf_next, acc_sum_ovf;

    // Modular subtraction folds the step into [-pi, pi); -2^(W-1) lands on -pi.
    assign delta = phi_i - prev_reg;

    assign delta_ext[PHASE_WIDTH-1:0] = delta;
    assign phi_ext[PHASE_WIDTH-1:0]   = phi_i;
    for (genvar gi = PHASE_WIDTH; gi < OW; gi++) begin : g_sext
        assign delta_ext[gi] = delta[PHASE_WIDTH-1];
        assign phi_ext[gi]   = phi_i[PHASE_WIDTH-1];
    end

    assign acc_sum     = acc_reg + delta_ext;
    assign acc_sum_ovf = (acc_reg[OW-1] == delta_ext[OW-1]) && (acc_sum[OW-1] != acc_reg[OW-1]);

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        acc_next   = acc_reg;
        valid_next = 1'b0;
        ovf_next   = ovf_reg;
        if (zero_i) begin
            ovf_next = 1'b0;
            if (phi_valid_i) begin
                acc_next   = '0;
                prev_next  = phi_i;
                valid_next = 1'b1;
                state_next = TRACK;
            end else begin
                state_next = ZERO;
            end
        end else if (phi_valid_i) begin
            prev_next  = phi_i;
            valid_next = 1'b1;
            state_next = TRACK;
            case (state_reg)
                FIRST:   acc_next = phi_ext;
                ZERO:    acc_next = '0;
                default: begin
                    acc_next = acc_sum;
                    if (acc_sum_ovf) begin
                        ovf_next = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg <= FIRST;
            prev_reg  <= '0;
            acc_reg   <= '0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            acc_reg   <= acc_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign unwrapped_o       = acc_reg;
    assign unwrapped_valid_o = valid_reg;
    assign overflow_o        = ovf_reg;

    // The block in flight is discarded on re-zero so averages never straddle references.
    phase_averager #(
        .WIDTH    (OW),
        .LOG2_AVG (LOG2_AVG)
    ) u_averager (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .in        (acc_reg),
        .in_valid  (valid_reg),
        .clear     (zero_i),
        .avg       (avg_o),
        .avg_valid (avg_valid_o)
    );

endmodule

// File: tb/tb_phase_unwrapper.sv
// Directed bench: one default unwrapper, one with 4-sample blocks, one with 2 turn bits.
module tb_phase_unwrapper;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [23:0] phi_i = '0;
    logic        phi_valid_i = 1'b0;
    logic        zero_i = 1'b0;

    logic signed [31:0] un_m, avg_m, un_a, avg_a;
    logic signed [25:0] un_o, avg_o26;
    logic uv_m, av_m, ov_m, uv_a, av_a, ov_a, uv_o, av_o, ov_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    phase_unwrapper #(.PHASE_WIDTH(24), .TURN_WIDTH(8), .LOG2_AVG(4)) u_main (
        .clk_i(clk_i), .reset_ni(reset_ni), .phi_i(phi_i), .phi_valid_i(phi_valid_i),
        .zero_i(zero_i), .unwrapped_o(un_m), .unwrapped_valid_o(uv_m),
        .avg_o(avg_m), .avg_valid_o(av_m), .overflow_o(ov_m));

    phase_unwrapper #(.PHASE_WIDTH(24), .TURN_WIDTH(8), .LOG2_AVG(2)) u_avg (
        .clk_i(clk_i), .reset_ni(reset_ni), .phi_i(phi_i), .phi_valid_i(phi_valid_i),
        .zero_i(zero_i), .unwrapped_o(un_a), .unwrapped_valid_o(uv_a),
        .avg_o(avg_a), .avg_valid_o(av_a), .overflow_o(ov_a));

    phase_unwrapper #(.PHASE_WIDTH(24), .TURN_WIDTH(2), .LOG2_AVG(4)) u_ovf (
        .clk_i(clk_i), .reset_ni(reset_ni), .phi_i(phi_i), .phi_valid_i(phi_valid_i),
        .zero_i(zero_i), .unwrapped_o(un_o), .unwrapped_valid_o(uv_o),
        .avg_o(avg_o26), .avg_valid_o(av_o), .overflow_o(ov_o));

    task automatic check(input string tag, input longint obs, input longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Apply inputs at a falling edge; return at the next falling edge after the capture.
    task automatic drive(input logic [23:0] phi, input logic v, input logic z);
        phi_i       = phi;
        phi_valid_i = v;
        zero_i      = z;
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(24'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        reset_ni = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    initial begin
        logic [23:0] step_phi;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_un", un_m, 0);
        check("rst_uv", uv_m, 0);
        check("rst_avg", avg_m, 0);
        check("rst_av", av_m, 0);
        check("rst_ovf", ov_m, 0);
        reset_ni = 1'b1;

        // First sample, latency 1
        drive(24'd1000, 1'b1, 1'b0);
        check("first_un", un_m, 1000);
        check("first_uv", uv_m, 1);
        idle();
        check("first_uv_end", uv_m, 0);
        drive(24'd2000, 1'b1, 1'b0);
        check("track_un", un_m, 2000);
        idle();

        // Asynchronous reset mid-block
        #1 reset_ni = 1'b0;
        #1;
        check("arst_un", un_m, 0);
        check("arst_ovf", ov_m, 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        drive(24'd3000, 1'b1, 1'b0);
        check("post_rst_un", un_m, 3000);
        idle();

        // Positive wrap
        reset_pulse();
        drive(24'(8000000), 1'b1, 1'b0);  check("pos_wrap0", un_m, 8000000);  idle();
        drive(24'(-8000000), 1'b1, 1'b0); check("pos_wrap1", un_m, 8777216);  idle();
        drive(24'(-7000000), 1'b1, 1'b0); check("pos_wrap2", un_m, 9777216);  idle();

        // Negative wrap, spaced then back-to-back
        reset_pulse();
        drive(24'(-8000000), 1'b1, 1'b0); check("neg_wrap0", un_m, -8000000); idle();
        drive(24'(8000000), 1'b1, 1'b0);  check("neg_wrap1", un_m, -8777216); idle();
        reset_pulse();
        drive(24'(-8000000), 1'b1, 1'b0); check("b2b_wrap0", un_m, -8000000);
        drive(24'(8000000), 1'b1, 1'b0);  check("b2b_wrap1", un_m, -8777216);
        check("b2b_uv", uv_m, 1);
        idle();

        // Step of exactly half a turn is taken as -pi
        reset_pulse();
        drive(24'd0, 1'b1, 1'b0);         check("halfturn0", un_m, 0);         idle();
        drive(24'h800000, 1'b1, 1'b0);    check("halfturn1", un_m, -8388608);  idle();
        drive(24'd0, 1'b1, 1'b0);         check("halfturn2", un_m, -16777216); idle();

        // Re-zero
        drive(24'd5000, 1'b1, 1'b1);      check("zero_with", un_m, 0);
        check("zero_with_uv", uv_m, 1);
        idle();
        drive(24'd6000, 1'b1, 1'b0);      check("after_zero", un_m, 1000);     idle();
        drive(24'd0, 1'b0, 1'b1);         check("zero_alone_uv", uv_m, 0);     idle();
        drive(24'd42, 1'b1, 1'b0);        check("zero_state", un_m, 0);        idle();

        // Averaging over 4-sample blocks after a re-zero
        drive(24'd100, 1'b1, 1'b1);       check("avg_s0", un_a, 0);            idle();
        drive(24'd104, 1'b1, 1'b0);       check("avg_s1", un_a, 4);            idle();
        drive(24'd108, 1'b1, 1'b0);       check("avg_s2", un_a, 8);            idle();
        drive(24'd113, 1'b1, 1'b0);       check("avg_s3", un_a, 13);
        check("avg_early", av_a, 0);
        idle();
        check("avg_blk1_v", av_a, 1);
        check("avg_blk1", avg_a, 6);
        idle();
        check("avg_blk1_end", av_a, 0);
        drive(24'd99, 1'b1, 1'b0);        check("avg_n0", un_a, -1);           idle();
        drive(24'd98, 1'b1, 1'b0);        check("avg_n1", un_a, -2);           idle();
        drive(24'd98, 1'b1, 1'b0);                                              idle();
        drive(24'd98, 1'b1, 1'b0);                                              idle();
        check("avg_blk2_v", av_a, 1);
        check("avg_blk2", avg_a, -2);

        // Overflow of the 26-bit accumulator
        reset_pulse();
        for (int k = 0; k < 11; k++) begin
            step_phi = 24'(k * 4000000);
            drive(step_phi, 1'b1, 1'b0);
            if (k == 8) begin
                check("ovf_s9_un", un_o, 32000000);
                check("ovf_s9_flag", ov_o, 0);
            end
            if (k == 9) begin
                check("ovf_s10_un", un_o, -31108864);
                check("ovf_s10_flag", ov_o, 1);
                check("wide_s10_un", un_m, 36000000);
                check("wide_s10_ovf", ov_m, 0);
            end
            if (k == 10) begin
                check("ovf_s11_un", un_o, -27108864);
                check("ovf_sticky", ov_o, 1);
            end
        end
        idle();
        check("ovf_hold", ov_o, 1);
        drive(24'd0, 1'b0, 1'b1);
        check("ovf_cleared", ov_o, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
